uart_bus_master: RTL
====================

// Module: uart_bus_master
// PURPOSE
//  Debug bridge that masters the CPU data bus from the host UART. Byte packets
//  arrive from the UART receiver, become single 32-bit read/write requests on the
//  16-bit-addressed cpud-style bus, and the result is returned as bytes to the
//  UART transmit FIFO. Lets the host peek/poke hardware registers without the CPU.
// PARAMETERS
//  TIMEOUT_CYCLES  1023  cycles to wait for bus ack before NAK (counter width = $clog2(TIMEOUT_CYCLES+1))
// PORTS
//  clock            in   1   system clock
//  reset            in   1   synchronous, active-high
//  rx_valid         in   1   one-cycle strobe: rx_data holds a received byte
//  rx_data          in   8   received byte
//  tx_valid         out  1   response byte available
//  tx_data          out  8   response byte
//  tx_ready         in   1   transmit FIFO accepts byte when tx_valid&&tx_ready
//  bus_request      out  1   one-cycle request pulse
//  bus_addr         out  16  byte address (from packet)
//  bus_write        out  1   1=write, 0=read
//  bus_byte_enable  out  4   always 4'hF during a request
//  bus_wdata        out  32  write data
//  bus_rdata        in   32  read data, valid with bus_ack
//  bus_ack          in   1   responder completion strobe
//  busy             out  1   high in any state other than IDLE
//  rx_overrun       out  1   one-cycle pulse: rx byte dropped (arrived in BUS_REQ/BUS_WAIT/RESP)
// BEHAVIOUR
//  Packet: cmd byte, addr lo, addr hi, [4 data bytes LSB first if write], [csum if BRIDGE_CSUM_EN].
//  cmd 0x57 'W' = write, 0x52 'R' = read; any other byte in IDLE silently ignored.
//  Reset: state IDLE, tx_valid=0, tx_data=0, bus_request=0, bus_write=0,
//   bus_byte_enable=0, bus_addr=0, bus_wdata=0, busy=0, rx_overrun=0, counters 0.
//  States: IDLE -> ADDR (2 bytes) -> DATA (4 bytes, write only) -> [CSUM] -> BUS_REQ
//   -> BUS_WAIT -> RESP -> IDLE. 3-bit byte counter indexes shift-in position.
//  BUS_REQ: bus_request=1 for exactly one cycle; addr/write/wdata/byte_enable held
//   stable from this cycle until leaving BUS_WAIT. Next state BUS_WAIT, timer cleared.
//  BUS_WAIT: timer increments each cycle; bus_ack -> latch rdata, result=OK.
//   timer==TIMEOUT_CYCLES without ack -> result=NAK. Ack in same cycle as expiry: ack wins.
//  Ack outside BUS_WAIT ignored (late ack after timeout must not corrupt next op).
//  RESP: write OK -> 1 byte 0x06; read OK -> 4 bytes rdata LSB first; NAK -> 1 byte 0x15.
//   tx_valid held with tx_data stable until tx_ready; next byte presented the cycle
//   after a transfer (no combinational ready->valid path). Last transfer -> IDLE.
//  Min latency last rx byte -> bus_request: 1 cycle; bus_ack -> tx_valid: 1 cycle.
//  rx bytes during BUS_REQ/BUS_WAIT/RESP dropped, rx_overrun pulses that cycle.
//  rx_valid is accepted in the same cycle as the IDLE->ADDR decision; no inter-byte timeout.
//  Reset asserted mid-operation: abort immediately, no further bus_request, pending tx byte discarded.
// CONFIGURATION
//  BRIDGE_CSUM_EN defined: extra trailing byte = XOR of all preceding packet bytes
//   (cmd included). Mismatch -> no bus transaction, respond 0x15, return IDLE.
//  BRIDGE_CSUM_EN undefined: no CSUM state; packet ends after addr/data bytes.
// TESTING
//  'R',0x08,0x00; ack after 3 cycles rdata=0x12345678 -> one request addr=0x0008 write=0; tx 78,56,34,12.
//  'W',0x04,0x00,0xAA,0x03,0,0 -> request addr=0x0004 wdata=0x000003AA be=F; ack -> tx 0x06.
//  'R',0x50,0x00, never ack -> NAK 0x15 exactly TIMEOUT_CYCLES+1 cycles after request; ack 5 cycles later ignored.
//  Bytes 0x00,0xFF,'R',0x10,0x00 -> only one read at 0x0010; junk bytes produce no tx.
//  tx_ready low 20 cycles during read response -> tx_data stable, no byte lost or duplicated.
//  With BRIDGE_CSUM_EN: 'W',4,0,1,0,0,0,bad csum -> no bus_request, tx 0x15; correct csum 0x52 -> write.

Source files
------------

// File: rtl/uart_bus_master_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_bus_master_if
// Description : cpud-style bus bundle between the UART debug bridge and the
//               responder it masters.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_bus_master_if;
    logic        bus_request;
    logic [15:0] bus_addr;
    logic        bus_write;
    logic [3:0]  bus_byte_enable;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_request, bus_addr, bus_write, bus_byte_enable, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_request, bus_addr, bus_write, bus_byte_enable, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface
`default_nettype wire

// File: rtl/uart_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : uart_bus_master
// Description : UART byte-packet to 32-bit bus read/write bridge for host
//               register peek/poke. Define BRIDGE_CSUM_EN to require a
//               trailing XOR checksum byte on every packet.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_bus_master #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  wire               clock,
    input  wire               reset,
    input  wire               rx_valid,
    input  wire  [7:0]        rx_data,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  wire               tx_ready,
    uart_bus_master_if.master bus,
    output logic              busy,
    output logic              rx_overrun
);

    localparam int         c_TIMER_W   = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0] c_CMD_WRITE = 8'h57;
    localparam logic [7:0] c_CMD_READ  = 8'h52;
    localparam logic [7:0] c_RSP_ACK   = 8'h06;
    localparam logic [7:0] c_RSP_NAK   = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_DATA     = 3'd2,
        ST_CSUM     = 3'd3,
        ST_BUS_REQ  = 3'd4,
        ST_BUS_WAIT = 3'd5,
        ST_RESP     = 3'd6
    } state_t;

    state_t                r_state;
    logic [2:0]            r_cnt;
    logic [c_TIMER_W-1:0]  r_timer;
    logic [31:0]           r_rdata;
    logic                  r_request;
    logic                  r_write;
    logic [3:0]            r_be;
    logic [15:0]           r_addr;
    logic [31:0]           r_wdata;
    logic                  r_tx_valid;
    logic [7:0]            r_tx_data;
    logic                  w_payload_done;

    // Last address byte of a read, or last data byte of a write.
    assign w_payload_done = rx_valid &&
                            (((r_state == ST_ADDR) && (r_cnt == 3'd1) && !r_write) ||
                             ((r_state == ST_DATA) && (r_cnt == 3'd3)));

`ifdef BRIDGE_CSUM_EN
    logic [7:0] r_csum;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_csum <= 8'h00;
        end else if (r_state == ST_IDLE) begin
            r_csum <= rx_data;
        end else if (rx_valid && ((r_state == ST_ADDR) || (r_state == ST_DATA))) begin
            r_csum <= r_csum ^ rx_data;
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 3'd0;
            r_timer    <= '0;
            r_rdata    <= 32'h0;
            r_request  <= 1'b0;
            r_write    <= 1'b0;
            r_be       <= 4'h0;
            r_addr     <= 16'h0;
            r_wdata    <= 32'h0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            r_request <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (rx_valid && ((rx_data == c_CMD_WRITE) || (rx_data == c_CMD_READ))) begin
                        r_write <= (rx_data == c_CMD_WRITE);
                        r_cnt   <= 3'd0;
                        r_state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (rx_valid) begin
                        r_addr <= {rx_data, r_addr[15:8]};
                        if (r_cnt == 3'd1) begin
                            r_cnt <= 3'd0;
                            if (r_write) r_state <= ST_DATA;
                        end else begin
                            r_cnt <= r_cnt + 3'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_valid) begin
                        r_wdata <= {rx_data, r_wdata[31:8]};
                        r_cnt   <= (r_cnt == 3'd3) ? 3'd0 : r_cnt + 3'd1;
                    end
                end
`ifdef BRIDGE_CSUM_EN
                ST_CSUM: begin
                    if (rx_valid) begin
                        if (rx_data == r_csum) begin
                            r_state   <= ST_BUS_REQ;
                            r_request <= 1'b1;
                            r_be      <= 4'hF;
                        end else begin
                            r_state    <= ST_RESP;
                            r_tx_valid <= 1'b1;
                            r_tx_data  <= c_RSP_NAK;
                            r_cnt      <= 3'd0;
                        end
                    end
                end
`endif
                ST_BUS_REQ: begin
                    r_state <= ST_BUS_WAIT;
                    r_timer <= '0;
                end
                ST_BUS_WAIT: begin
                    // Ack is checked first so it wins over a simultaneous expiry.
                    if (bus.bus_ack) begin
                        r_state    <= ST_RESP;
                        r_be       <= 4'h0;
                        r_tx_valid <= 1'b1;
                        if (r_write) begin
                            r_tx_data <= c_RSP_ACK;
                            r_cnt     <= 3'd0;
                        end else begin
                            r_tx_data <= bus.bus_rdata[7:0];
                            r_rdata   <= {8'h00, bus.bus_rdata[31:8]};
                            r_cnt     <= 3'd3;
                        end
                    end else if (r_timer == c_TIMER_W'(TIMEOUT_CYCLES)) begin
                        r_state    <= ST_RESP;
                        r_be       <= 4'h0;
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= c_RSP_NAK;
                        r_cnt      <= 3'd0;
                    end else begin
                        r_timer <= r_timer + c_TIMER_W'(1);
                    end
                end
                ST_RESP: begin
                    // r_cnt holds the number of bytes still queued behind tx_data.
                    if (r_tx_valid && tx_ready) begin
                        if (r_cnt == 3'd0) begin
                            r_tx_valid <= 1'b0;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_cnt     <= r_cnt - 3'd1;
                            r_tx_data <= r_rdata[7:0];
                            r_rdata   <= {8'h00, r_rdata[31:8]};
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_payload_done) begin
`ifdef BRIDGE_CSUM_EN
                r_state <= ST_CSUM;
`else
                r_state   <= ST_BUS_REQ;
                r_request <= 1'b1;
                r_be      <= 4'hF;
`endif
            end
        end
    end

    assign bus.bus_request     = r_request;
    assign bus.bus_addr        = r_addr;
    assign bus.bus_write       = r_write;
    assign bus.bus_byte_enable = r_be;
    assign bus.bus_wdata       = r_wdata;

    assign tx_valid   = r_tx_valid;
    assign tx_data    = r_tx_data;
    assign busy       = (r_state != ST_IDLE);
    assign rx_overrun = !reset && rx_valid &&
                        ((r_state == ST_BUS_REQ) || (r_state == ST_BUS_WAIT) || (r_state == ST_RESP));

endmodule
`default_nettype wire
